// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time base and BCD digit chain.
package stopwatch_pkg;

    localparam int BCD_WIDTH = 4;

    localparam logic [BCD_WIDTH-1:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [BCD_WIDTH-1:0] DIGIT_MAX_5 = 4'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_e;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the time chain; rolls over to 0 past MAX and passes the carry up.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [BCD_WIDTH-1:0] MAX = DIGIT_MAX_9
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 carry_in,
    output logic [BCD_WIDTH-1:0] digit,
    output logic                 carry_out
);

    logic [BCD_WIDTH-1:0] digit_q;
    logic [BCD_WIDTH-1:0] digit_d;

    // ">=" keeps an out-of-range value from ever counting further into 10-15.
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (carry_in) begin
            digit_d = (digit_q >= MAX) ? '0 : digit_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign carry_out = carry_in & (digit_q == MAX);

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch core: clock prescaler to a 1/100 s tick, run/pause/clear FSM and MM:SS.cc BCD chain.
//   state   | meaning
//   IDLE    | time zero, stopped, prescaler held at 0
//   RUNNING | prescaler counting, digits advance on every tick
//   PAUSED  | stopped, digits and partial prescaler count held
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int TICK_HZ    = 100
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_stop,
    input  logic                 clear,
    output logic [BCD_WIDTH-1:0] cs_ones,
    output logic [BCD_WIDTH-1:0] cs_tens,
    output logic [BCD_WIDTH-1:0] sec_ones,
    output logic [BCD_WIDTH-1:0] sec_tens,
    output logic [BCD_WIDTH-1:0] min_ones,
    output logic [BCD_WIDTH-1:0] min_tens,
    output logic                 running,
    output logic                 wrap
);

    localparam int DIVIDE = CLOCK_FREQ / TICK_HZ;
    localparam int PRE_W  = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam logic [PRE_W-1:0] PRESC_LAST = PRE_W'(DIVIDE - 1);

    if (DIVIDE < 2) begin : g_divide_check
        $error("stopwatch_bcd_counter: CLOCK_FREQ/TICK_HZ must be at least 2");
    end

    sw_state_e        state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             running_q;
    logic             wrap_q;
    logic             clr_digits;
    logic             tick;
    logic [6:0]       carry;

    assign tick = (state_q == RUNNING) && (presc_q == PRESC_LAST);

    // clear beats start_stop only in PAUSED; elsewhere clear has no effect.
    always_comb begin
        state_d    = state_q;
        clr_digits = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_stop) state_d = RUNNING;
            end
            RUNNING: begin
                if (start_stop) state_d = PAUSED;
            end
            PAUSED: begin
                if (clear) begin
                    state_d    = IDLE;
                    clr_digits = 1'b1;
                end else if (start_stop) begin
                    state_d = RUNNING;
                end
            end
            default: begin
                state_d    = IDLE;
                clr_digits = 1'b1;
            end
        endcase
    end

    always_comb begin
        presc_d = presc_q;
        if (clr_digits || (state_q == IDLE)) begin
            presc_d = '0;
        end else if (state_q == RUNNING) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            running_q <= (state_d == RUNNING);
            wrap_q    <= carry[6];
        end
    end

    assign carry[0] = tick;

    bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_cs_ones (
        .clock(clock), .reset(reset), .clr(clr_digits),
        .carry_in(carry[0]), .digit(cs_ones), .carry_out(carry[1])
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_cs_tens (
        .clock(clock), .reset(reset), .clr(clr_digits),
        .carry_in(carry[1]), .digit(cs_tens), .carry_out(carry[2])
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_sec_ones (
        .clock(clock), .reset(reset), .clr(clr_digits),
        .carry_in(carry[2]), .digit(sec_ones), .carry_out(carry[3])
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX_5)) u_sec_tens (
        .clock(clock), .reset(reset), .clr(clr_digits),
        .carry_in(carry[3]), .digit(sec_tens), .carry_out(carry[4])
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_min_ones (
        .clock(clock), .reset(reset), .clr(clr_digits),
        .carry_in(carry[4]), .digit(min_ones), .carry_out(carry[5])
    );

    // Carry out of the top digit is exactly the 59:59.99 rollover.
    bcd_digit_counter #(.MAX(DIGIT_MAX_5)) u_min_tens (
        .clock(clock), .reset(reset), .clr(clr_digits),
        .carry_in(carry[5]), .digit(min_tens), .carry_out(carry[6])
    );

    assign running = running_q;
    assign wrap    = wrap_q;

endmodule
